// File: rtl/lot_gate_arbiter_if.sv
// Lane-side bus of the parking-lot gate arbiter: lane requests and car-passed
// pulses in one direction, gate controls and occupancy status in the other.
interface lot_gate_arbiter_if #(
  parameter int CNT_W = 5
);
  logic             ent_req;
  logic             ext_req;
  logic             ent_pass;
  logic             ext_pass;
  logic             ent_open;
  logic             ext_open;
  logic             ent_gnt;
  logic             ext_gnt;
  logic             timeout;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  // Sensor front ends / display side: drives requests and passes, observes gates.
  modport master (
    output ent_req, ext_req, ent_pass, ext_pass,
    input  ent_open, ext_open, ent_gnt, ext_gnt, timeout, count, full, empty
  );

  // Arbiter side.
  modport slave (
    input  ent_req, ext_req, ent_pass, ext_pass,
    output ent_open, ext_open, ent_gnt, ext_gnt, timeout, count, full, empty
  );
endinterface

// File: rtl/lot_gate_arbiter.sv
// Shares the lot occupancy count between the entry and exit lanes. One gate is
// open at a time; it closes on the lane's pass pulse (updating occupancy) or
// after OPEN_CYCLES cycles without a pass (timeout, occupancy unchanged).
module lot_gate_arbiter #(
  parameter int CAPACITY    = 25,
  parameter int CNT_W       = 5,
  parameter int OPEN_CYCLES = 8,
  parameter int TMR_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  lot_gate_arbiter_if.slave    gate
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENT_OPEN = 2'd1,
    EXT_OPEN = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE   = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(OPEN_CYCLES - 1);

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [TMR_W-1:0] timer_q,    timer_d;
  logic             last_ent_q, last_ent_d;   // 1: last contested grant went to entry
  logic             ent_open_q, ent_open_d;
  logic             ext_open_q, ext_open_d;
  logic             ent_gnt_q,  ent_gnt_d;
  logic             ext_gnt_q,  ext_gnt_d;
  logic             timeout_q,  timeout_d;

  logic             full_s;
  logic             empty_s;
  logic             ent_elig_s;
  logic             ext_elig_s;

  assign full_s     = (count_q == CAP_C);
  assign empty_s    = (count_q == CNT_ZERO);
  assign ent_elig_s = gate.ent_req && !full_s;
  assign ext_elig_s = gate.ext_req && !empty_s;

  // Next-state: arbitration in IDLE, pass/timeout handling while a gate is open.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    timer_d    = timer_q;
    last_ent_d = last_ent_q;
    ent_gnt_d  = 1'b0;
    ext_gnt_d  = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Entry wins when it is alone, or when both contend and exit went last.
        if (ent_elig_s && (!ext_elig_s || !last_ent_q)) begin
          state_d   = ENT_OPEN;
          ent_gnt_d = 1'b1;
          timer_d   = TMR_LOAD;
          if (ext_elig_s) begin
            last_ent_d = 1'b1;
          end else begin
            last_ent_d = last_ent_q;
          end
        end else if (ext_elig_s) begin
          state_d   = EXT_OPEN;
          ext_gnt_d = 1'b1;
          timer_d   = TMR_LOAD;
          if (ent_elig_s) begin
            last_ent_d = 1'b0;
          end else begin
            last_ent_d = last_ent_q;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ENT_OPEN: begin
        // A pass on the last timer cycle still counts; it beats the timeout.
        if (gate.ent_pass) begin
          count_d = count_q + CNT_ONE;
          state_d = IDLE;
        end else if (timer_q == TMR_ZERO) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      EXT_OPEN: begin
        if (gate.ext_pass) begin
          count_d = count_q - CNT_ONE;
          state_d = IDLE;
        end else if (timer_q == TMR_ZERO) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ent_open_d = (state_d == ENT_OPEN);
    ext_open_d = (state_d == EXT_OPEN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= CNT_ZERO;
      timer_q    <= TMR_ZERO;
      last_ent_q <= 1'b0;
      ent_open_q <= 1'b0;
      ext_open_q <= 1'b0;
      ent_gnt_q  <= 1'b0;
      ext_gnt_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      last_ent_q <= last_ent_d;
      ent_open_q <= ent_open_d;
      ext_open_q <= ext_open_d;
      ent_gnt_q  <= ent_gnt_d;
      ext_gnt_q  <= ext_gnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gate.ent_open = ent_open_q;
  assign gate.ext_open = ext_open_q;
  assign gate.ent_gnt  = ent_gnt_q;
  assign gate.ext_gnt  = ext_gnt_q;
  assign gate.timeout  = timeout_q;
  assign gate.count    = count_q;
  assign gate.full     = full_s;
  assign gate.empty    = empty_s;

endmodule
